barrel_shifter_pipe: RTL and testbench

//  Parametrised, pipelined log-stage barrel shifter: one register stage per shift bit, each stage shifting by 2^k.

---
 rtl/barrel_shifter_pipe.sv | 140 ++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: log-stage pipelined barrel shifter (stage k shifts by 2^k) with valid/ready flow control.
// Define BSHIFT_FLAGS_EN to add the pipelined out_zero / out_carry result flags.
module barrel_shifter_pipe #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_dir,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef BSHIFT_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);
  localparam logic [1:0] MODE_ARI  = 2'b01;
  localparam logic [1:0] MODE_ROT  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  logic advance;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stg
    localparam int SH = 1 << k;

    logic               src_vld, src_dir, src_sign;
    logic [WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0] src_shamt;
    logic [1:0]         src_mode;

    logic               vld_q, dir_q, sign_q;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         mode_q;
`ifdef BSHIFT_FLAGS_EN
    logic               src_carry, carry_d, carry_q;
`endif

    if (k == 0) begin : g_src
      assign src_vld   = in_valid;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_dir   = in_dir;
      assign src_mode  = in_mode;
      assign src_sign  = in_data[WIDTH-1];
`ifdef BSHIFT_FLAGS_EN
      assign src_carry = 1'b0;
`endif
    end else begin : g_src
      assign src_vld   = g_stg[k-1].vld_q;
      assign src_data  = g_stg[k-1].data_q;
      assign src_shamt = g_stg[k-1].shamt_q;
      assign src_dir   = g_stg[k-1].dir_q;
      assign src_mode  = g_stg[k-1].mode_q;
      assign src_sign  = g_stg[k-1].sign_q;
`ifdef BSHIFT_FLAGS_EN
      assign src_carry = g_stg[k-1].carry_q;
`endif
    end

    always_comb begin
      data_d = src_data;
      if (src_shamt[k] && src_mode != MODE_PASS) begin
        case (src_mode)
          MODE_ROT: data_d = src_dir ? ((src_data >> SH) | (src_data << (WIDTH - SH)))
                                     : ((src_data << SH) | (src_data >> (WIDTH - SH)));
          // sign is the operand's original MSB, carried alongside the data
          MODE_ARI: data_d = src_dir ? (({WIDTH{src_sign}} << (WIDTH - SH)) | (src_data >> SH))
                                     : (src_data << SH);
          default:  data_d = src_dir ? (src_data >> SH) : (src_data << SH);
        endcase
      end
    end

`ifdef BSHIFT_FLAGS_EN
    always_comb begin
      carry_d = src_carry;
      if (src_shamt[k] && src_mode != MODE_PASS)
        carry_d = src_dir ? src_data[SH-1] : src_data[WIDTH-SH];
    end
`endif

    // payload only loads on a real beat so bubbles never disturb out_data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q   <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        dir_q   <= 1'b0;
        mode_q  <= '0;
        sign_q  <= 1'b0;
`ifdef BSHIFT_FLAGS_EN
        carry_q <= 1'b0;
`endif
      end else if (advance) begin
        vld_q <= src_vld;
        if (src_vld) begin
          data_q  <= data_d;
          shamt_q <= src_shamt;
          dir_q   <= src_dir;
          mode_q  <= src_mode;
          sign_q  <= src_sign;
`ifdef BSHIFT_FLAGS_EN
          carry_q <= carry_d;
`endif
        end
      end
    end
  end

  assign out_valid = g_stg[SHAMT_W-1].vld_q;
  assign out_data  = g_stg[SHAMT_W-1].data_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  logic unused_tail;
  assign unused_tail = ^{g_stg[SHAMT_W-1].shamt_q, g_stg[SHAMT_W-1].dir_q,
                         g_stg[SHAMT_W-1].mode_q, g_stg[SHAMT_W-1].sign_q};

`ifdef BSHIFT_FLAGS_EN
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero_q <= 1'b0;
    else if (advance && g_stg[SHAMT_W-1].src_vld)
      zero_q <= (g_stg[SHAMT_W-1].data_d == '0);
  end

  assign out_zero  = zero_q;
  assign out_carry = g_stg[SHAMT_W-1].carry_q;
`endif
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed vector table, stream/stall/reset sequences,
// and a randomized stream scored against a plain-arithmetic reference model.
module tb_barrel_shifter_pipe;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, in_dir, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_mode;
`ifdef BSHIFT_FLAGS_EN
  logic          out_zero, out_carry;
`endif

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_dir(in_dir), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BSHIFT_FLAGS_EN
    , .out_zero(out_zero), .out_carry(out_carry)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  bit acc_last = 1'b0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    int          sh;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] exp;
    logic        exp_c;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // result = {carry, data}: carry is the last bit pushed off the end
  function automatic logic [W:0] model(input logic [W-1:0] d, input int sh, input logic dir,
                                       input logic [1:0] mode);
    logic [W-1:0] r;
    logic         c;
    r = d;
    c = 1'b0;
    if (mode != 2'b11 && sh != 0) begin
      case (mode)
        2'b00:   r = dir ? d >> sh : d << sh;
        2'b01:   r = dir ? W'($signed(d) >>> sh) : d << sh;
        default: r = dir ? ((d >> sh) | (d << (W - sh))) : ((d << sh) | (d >> (W - sh)));
      endcase
      c = dir ? d[sh-1] : d[W-sh];
    end
    return {c, r};
  endfunction

  always @(negedge clk) begin
    logic [W:0] e;
    acc_last = in_valid && in_ready && !rst;
    if (!rst) begin
      if (in_valid && in_ready)
        exp_q.push_back(model(in_data, int'(in_shamt), in_dir, in_mode));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got beat %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", out_data, e[W-1:0]);
`ifdef BSHIFT_FLAGS_EN
          check("stream_carry", out_carry, e[W]);
          check("stream_zero", out_zero, e[W-1:0] == '0);
`endif
        end
      end
    end
  end

  task automatic rand_beat();
    in_valid = 1'b1;
    in_data  = $urandom;
    in_shamt = SW'($urandom_range(W - 1));
    in_dir   = 1'($urandom_range(1));
    in_mode  = 2'($urandom_range(3));
  endtask

  task automatic run_beat(input int idx, input vec_t v);
    int lat;
    bit got;
    @(posedge clk); #1;
    check($sformatf("vec%0d_idle_ready", idx), in_ready, 1);
    in_valid = 1'b1; in_data = v.data; in_shamt = SW'(v.sh); in_dir = v.dir; in_mode = v.mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (out_valid) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    check($sformatf("vec%0d_seen", idx), got, 1);
    if (got) begin
      check($sformatf("vec%0d_latency", idx), lat, SW);
      check($sformatf("vec%0d_data", idx), out_data, v.exp);
`ifdef BSHIFT_FLAGS_EN
      check($sformatf("vec%0d_carry", idx), out_carry, v.exp_c);
      check($sformatf("vec%0d_zero", idx), out_zero, v.exp == 32'h0);
`endif
      repeat (4) begin @(posedge clk); #1; end
      check($sformatf("vec%0d_idle_valid", idx), out_valid, 0);
      check($sformatf("vec%0d_idle_hold", idx), out_data, v.exp);
    end
  endtask

  task automatic drive_stream(input int n, input int vprob, input int rprob, input int stall_at);
    int sent = 0;
    int cyc = 0;
    int base = n_out;
    logic [W-1:0] held = '0;
    while (sent < n && cyc < 5000) begin
      @(posedge clk); #1;
      if (in_valid && acc_last) sent++;
      if (!in_valid || acc_last) begin
        if (sent < n && $urandom_range(99) < vprob) rand_beat();
        else in_valid = 1'b0;
      end
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3) begin
        out_ready = 1'b0;
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
        if (cyc == stall_at) held = out_data;
        else check("stall_hold", out_data, held);
      end else begin
        out_ready = ($urandom_range(99) < rprob);
      end
      cyc++;
    end
    in_valid  = 1'b0;
    check("stream_sent", sent, n);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("stream_count", n_out - base, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] vhist;
    int ones, first, last;
    bit seen;

    vecs[0]  = '{32'h8000_0001,  4, 1'b0, 2'b00, 32'h0000_0010, 1'b0};
    vecs[1]  = '{32'h8000_0000, 31, 1'b1, 2'b01, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h8000_0000, 31, 1'b1, 2'b00, 32'h0000_0001, 1'b0};
    vecs[3]  = '{32'h1234_ABCD, 16, 1'b1, 2'b10, 32'hABCD_1234, 1'b1};
    vecs[4]  = '{32'h1234_ABCD, 16, 1'b1, 2'b11, 32'h1234_ABCD, 1'b0};
    vecs[5]  = '{32'hC000_0000,  1, 1'b0, 2'b00, 32'h8000_0000, 1'b1};
    vecs[6]  = '{32'h0000_0001,  1, 1'b1, 2'b00, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'hDEAD_BEEF,  0, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{32'hDEAD_BEEF,  0, 1'b0, 2'b10, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{32'h8000_0001,  1, 1'b0, 2'b10, 32'h0000_0003, 1'b1};
    vecs[10] = '{32'h0000_0001, 31, 1'b0, 2'b00, 32'h8000_0000, 1'b0};
    vecs[11] = '{32'h7FFF_FFFF, 31, 1'b1, 2'b01, 32'h0000_0000, 1'b1};
    vecs[12] = '{32'h8765_4321,  8, 1'b0, 2'b01, 32'h6543_2100, 1'b1};
    vecs[13] = '{32'hF000_000F,  4, 1'b1, 2'b11, 32'hF000_000F, 1'b0};

    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 1);
`ifdef BSHIFT_FLAGS_EN
    check("reset_zero", out_zero, 0);
    check("reset_carry", out_carry, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_beat(i, vecs[i]);

    // 8 back-to-back beats must come out as 8 consecutive valid cycles
    vhist = '0;
    fork
      begin
        for (int c = 0; c < 30; c++) begin @(negedge clk); vhist[c] = out_valid; end
      end
    join_none
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rand_beat();
      #1;
      check("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    ones = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (vhist[c]) begin
        ones++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("b2b_valid_count", ones, 8);
    check("b2b_valid_span", last - first + 1, 8);

    drive_stream(12, 100, 100, 7);
    drive_stream(300, 70, 70, -1);

    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_beat(); @(posedge clk); #1; end
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("midrst_no_stale", seen, 0);
    check("midrst_data_quiet", out_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
